// File: rtl/tick_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// tick_sched_ctrl_if
// Groups the configuration handshake, run control and status signals of the
// tick scheduler.
//   master : system controller side (drives cfg_*, start, stop, pause)
//   slave  : scheduler side (drives cfg_ready, ce_out, count, tc, busy, done)
// Optional feature macro: TICK_SCHED_PAUSE_EN adds the pause request line.
// ---------------------------------------------------------------------------
interface tick_sched_ctrl_if #(
  parameter int PRESC_W = 8,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PRESC_W-1:0] cfg_presc;
  logic [CNT_W-1:0]   cfg_period;
  logic               cfg_mode;
  logic               start;
  logic               stop;
`ifdef TICK_SCHED_PAUSE_EN
  logic               pause;
`endif
  logic               ce_out;
  logic [CNT_W-1:0]   count;
  logic               tc;
  logic               busy;
  logic               done;

  modport master (
`ifdef TICK_SCHED_PAUSE_EN
    output pause,
`endif
    output cfg_valid, cfg_presc, cfg_period, cfg_mode, start, stop,
    input  cfg_ready, ce_out, count, tc, busy, done
  );

  modport slave (
`ifdef TICK_SCHED_PAUSE_EN
    input  pause,
`endif
    input  cfg_valid, cfg_presc, cfg_period, cfg_mode, start, stop,
    output cfg_ready, ce_out, count, tc, busy, done
  );
endinterface

// File: rtl/tick_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tick_sched_ctrl
// Programmable tick scheduler: a prescaler produces a one-cycle enable
// (ce_out) every presc_r+1 RUN cycles, and a period counter advances on each
// enable, wrapping after period_r and flagging tc on the wrapping enable.
// One-shot runs end in DONE on tc; periodic runs keep going until stop.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : tick_sched_ctrl_if.slave (cfg handshake, start/stop, status)
// Optional feature macro: TICK_SCHED_PAUSE_EN adds the pause input and a
// PAUSE state that freezes the prescaler and period counter.
// ---------------------------------------------------------------------------
module tick_sched_ctrl #(
  parameter int PRESC_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  tick_sched_ctrl_if.slave bus
);

`ifdef TICK_SCHED_PAUSE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PRESC_W-1:0] presc_cnt_r;
  logic [PRESC_W-1:0] presc_cnt_nxt_s;
  logic [PRESC_W-1:0] presc_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [CNT_W-1:0]   period_r;
  logic               mode_r;
  logic               pause_s;
  logic               paused_s;
  logic               presc_wrap_s;
  logic               count_wrap_s;
  logic               ce_s;
  logic               tc_s;
  logic               cfg_ready_s;
  logic               cfg_take_s;

`ifdef TICK_SCHED_PAUSE_EN
  assign pause_s  = bus.pause;
  assign paused_s = (state_r == ST_PAUSE);
`else
  assign pause_s  = 1'b0;
  assign paused_s = 1'b0;
`endif

  assign presc_wrap_s = (presc_cnt_r == presc_r);
  assign count_wrap_s = (count_r == period_r);
  // The enable is suppressed by stop and by a pause request in the same cycle,
  // so a pause never swallows a tick: the frozen phase replays it on resume.
  assign ce_s         = (state_r == ST_RUN) && !bus.stop && !pause_s && presc_wrap_s;
  assign tc_s         = ce_s && count_wrap_s;
  assign cfg_ready_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign cfg_take_s   = bus.cfg_valid && cfg_ready_s;

  assign bus.cfg_ready = cfg_ready_s;
  assign bus.ce_out    = ce_s;
  assign bus.tc        = tc_s;
  assign bus.count     = count_r;
  assign bus.busy      = (state_r == ST_RUN) || paused_s;
  assign bus.done      = (state_r == ST_DONE);

  // Configuration registers, loaded on an accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r  <= '0;
      period_r <= '0;
      mode_r   <= 1'b0;
    end else if (cfg_take_s) begin
      presc_r  <= bus.cfg_presc;
      period_r <= bus.cfg_period;
      mode_r   <= bus.cfg_mode;
    end
  end

  // State, prescaler and period counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      presc_cnt_r <= '0;
      count_r     <= '0;
    end else begin
      state_r     <= state_nxt_s;
      presc_cnt_r <= presc_cnt_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

  // Next-state and counter update; stop outranks start, pause and tc.
  always_comb begin
    state_nxt_s     = state_r;
    presc_cnt_nxt_s = presc_cnt_r;
    count_nxt_s     = count_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.stop) begin
          state_nxt_s     = ST_IDLE;
          presc_cnt_nxt_s = '0;
          count_nxt_s     = '0;
        end else if (bus.start) begin
          state_nxt_s     = ST_RUN;
          presc_cnt_nxt_s = '0;
          count_nxt_s     = '0;
        end else begin
          state_nxt_s     = state_r;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nxt_s     = ST_IDLE;
          presc_cnt_nxt_s = '0;
          count_nxt_s     = '0;
        end else if (pause_s) begin
`ifdef TICK_SCHED_PAUSE_EN
          state_nxt_s     = ST_PAUSE;
`else
          state_nxt_s     = ST_RUN;
`endif
        end else begin
          presc_cnt_nxt_s = presc_wrap_s ? '0 : presc_cnt_r + 1'b1;
          if (ce_s) begin
            count_nxt_s = count_wrap_s ? '0 : count_r + 1'b1;
          end else begin
            count_nxt_s = count_r;
          end
          if (tc_s && !mode_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
`ifdef TICK_SCHED_PAUSE_EN
      ST_PAUSE: begin
        if (bus.stop) begin
          state_nxt_s     = ST_IDLE;
          presc_cnt_nxt_s = '0;
          count_nxt_s     = '0;
        end else if (!pause_s) begin
          state_nxt_s     = ST_RUN;
        end else begin
          state_nxt_s     = ST_PAUSE;
        end
      end
`endif
      default: begin
        state_nxt_s     = ST_IDLE;
        presc_cnt_nxt_s = '0;
        count_nxt_s     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tick_sched_ctrl
// Directed bench for tick_sched_ctrl. A table of per-cycle input/expected
// records drives the main sequences; hand-written sequences cover the
// asynchronous reset, reset configuration values and (with
// TICK_SCHED_PAUSE_EN) pause/resume. Expected outputs are packed as
// {ce_out, count[7:0], tc, busy, done, cfg_ready}.
// ---------------------------------------------------------------------------
module tb_tick_sched_ctrl;

  typedef struct {
    logic        cv;
    logic [7:0]  presc;
    logic [7:0]  period;
    logic        mode;
    logic        start;
    logic        stop;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tick_sched_ctrl_if #(.PRESC_W(8), .CNT_W(8)) bus ();

  tick_sched_ctrl #(.PRESC_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [12:0] e(input int ce, input int cnt, input int tc,
                                    input int busy, input int done, input int rdy);
    return {ce[0], cnt[7:0], tc[0], busy[0], done[0], rdy[0]};
  endfunction

  task automatic add(input int cv, input int presc, input int period, input int mode,
                     input int start, input int stop, input int ce, input int cnt,
                     input int tc, input int busy, input int done, input int rdy);
    vec_t v;
    v.cv     = cv[0];
    v.presc  = presc[7:0];
    v.period = period[7:0];
    v.mode   = mode[0];
    v.start  = start[0];
    v.stop   = stop[0];
    v.exp    = e(ce, cnt, tc, busy, done, rdy);
    vecs.push_back(v);
  endtask

  task automatic check_now(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {bus.ce_out, bus.count, bus.tc, bus.busy, bus.done, bus.cfg_ready};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: ce/count/tc/busy/done/ready got %b, expected %b", name, act, exp);
  endtask

  task automatic drive(input int cv, input int presc, input int period, input int mode,
                       input int start, input int stop);
    bus.cfg_valid  = cv[0];
    bus.cfg_presc  = presc[7:0];
    bus.cfg_period = period[7:0];
    bus.cfg_mode   = mode[0];
    bus.start      = start[0];
    bus.stop       = stop[0];
  endtask

  task automatic cycle(input string name, input logic [12:0] exp);
    @(negedge clk);
    check_now(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
`ifdef TICK_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif

    // Periodic run, presc=2 period=3; a cfg offer during RUN is ignored.
    add(1,2,3,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0, 0,0,0,0,0,1);
    add(0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(1,5,3,1,0,0, 0,1,0,1,0,0);
    add(1,5,3,1,0,0, 0,1,0,1,0,0);
    add(1,5,3,1,0,0, 1,1,0,1,0,0);
    add(1,5,3,1,0,0, 0,2,0,1,0,0);
    add(1,5,3,1,0,0, 0,2,0,1,0,0);
    add(1,5,3,1,0,0, 1,2,0,1,0,0);
    add(1,5,3,1,0,0, 0,3,0,1,0,0);
    add(1,5,3,1,0,0, 0,3,0,1,0,0);
    add(1,5,3,1,0,0, 1,3,1,1,0,0);
    add(1,5,3,1,0,0, 0,0,0,1,0,0);
    add(1,5,3,1,0,0, 0,0,0,1,0,0);
    add(1,5,3,1,0,0, 1,0,0,1,0,0);
    add(1,5,3,1,0,1, 0,1,0,1,0,0);
    // Held offer accepted once idle; the new divisor gives ticks every 6 cycles.
    add(1,5,3,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0, 0,0,0,0,0,1);
    for (int k = 0; k < 5; k++) add(0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0,0,0, 0,1,0,1,0,0);
    add(0,0,0,0,0,0, 1,1,0,1,0,0);
    add(0,0,0,0,0,1, 0,2,0,1,0,0);
    // Config with start in one cycle; stop masks the would-be terminal tick.
    add(1,1,3,0,1,0, 0,0,0,0,0,1);
    add(0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,1,0,1,0,0);
    add(0,0,0,0,0,0, 1,1,0,1,0,0);
    add(0,0,0,0,0,0, 0,2,0,1,0,0);
    add(0,0,0,0,0,0, 1,2,0,1,0,0);
    add(0,0,0,0,0,0, 0,3,0,1,0,0);
    add(0,0,0,0,0,1, 0,3,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,1);
    // One-shot presc=0 period=4, DONE hold, restart from DONE, stop.
    add(1,0,4,0,1,0, 0,0,0,0,0,1);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,1,0,1,0,0);
    add(0,0,0,0,0,0, 1,2,0,1,0,0);
    add(0,0,0,0,0,0, 1,3,0,1,0,0);
    add(0,0,0,0,0,0, 1,4,1,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,1,1);
    add(0,0,0,0,1,0, 0,0,0,0,1,1);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,1, 0,1,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,1);
    // stop outranks start in IDLE.
    add(0,0,0,0,1,1, 0,0,0,0,0,1);
    add(0,0,0,0,0,0, 0,0,0,0,0,1);

    #2;
    check_now("reset state", e(0,0,0,0,0,1));
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].presc, vecs[i].period, vecs[i].mode,
            vecs[i].start, vecs[i].stop);
      cycle($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a run with count=2.
    drive(1, 0, 9, 1, 1, 0);
    cycle("t1 cfg+start", e(0,0,0,0,0,1));
    drive(0, 0, 0, 0, 0, 0);
    cycle("t1 run0", e(1,0,0,1,0,0));
    cycle("t1 run1", e(1,1,0,1,0,0));
    @(negedge clk);
    check_now("t1 run2", e(1,2,0,1,0,0));
    rst = 1'b0;
    #1;
    check_now("t1 async reset", e(0,0,0,0,0,1));
    @(posedge clk);
    #1;
    check_now("t1 held in reset", e(0,0,0,0,0,1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) cycle($sformatf("t1 idle%0d", k), e(0,0,0,0,0,1));
    // Reset cleared presc/period/mode: a run ticks and terminates at once.
    drive(0, 0, 0, 0, 1, 0);
    cycle("t1 start", e(0,0,0,0,0,1));
    drive(0, 0, 0, 0, 0, 0);
    cycle("t1 reset cfg tick", e(1,0,1,1,0,0));
    cycle("t1 reset cfg done", e(0,0,0,0,1,1));

`ifdef TICK_SCHED_PAUSE_EN
    // Pause held 10 cycles at count=1 with prescaler phase 1, then stop in PAUSE.
    drive(1, 2, 3, 1, 1, 0);
    cycle("t6 cfg+start", e(0,0,0,0,1,1));
    drive(0, 0, 0, 0, 0, 0);
    cycle("t6 run0", e(0,0,0,1,0,0));
    cycle("t6 run1", e(0,0,0,1,0,0));
    cycle("t6 run2", e(1,0,0,1,0,0));
    cycle("t6 run3", e(0,1,0,1,0,0));
    bus.pause = 1'b1;
    for (int k = 0; k < 10; k++) cycle($sformatf("t6 pause%0d", k), e(0,1,0,1,0,0));
    bus.pause = 1'b0;
    cycle("t6 release", e(0,1,0,1,0,0));
    cycle("t6 resume0", e(0,1,0,1,0,0));
    cycle("t6 resume1", e(1,1,0,1,0,0));
    cycle("t6 resume2", e(0,2,0,1,0,0));
    bus.pause = 1'b1;
    cycle("t6 pause again", e(0,2,0,1,0,0));
    bus.stop = 1'b1;
    cycle("t6 stop in pause", e(0,2,0,1,0,0));
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    cycle("t6 idle", e(0,0,0,0,0,1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
